// File: rtl/csea_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// csea_serial_add_ctrl
//
// Purpose:
//   Sequencer that computes a W-bit add or subtract using one shared SLICE-bit
//   carry-select slice (csea_level). It processes the operands one slice per
//   clock, starting with the least significant slice. A register carries the
//   carry from one slice to the next. This trades latency for area compared
//   with a fully parallel W-bit carry-select adder.
//
// Ports:
//   clk          rising-edge clock
//   rst_b        asynchronous reset, active-low
//   in_valid     operands/opcode valid (ignored unless in_ready)
//   in_ready     controller idle and able to accept an operation
//   x, y         W-bit operands A and B
//   sub          0: A+B+c_in, 1: A-B (c_in ignored)
//   c_in         carry-in for add
//   slice_x      slice operand A, to csea_level.x
//   slice_y      slice operand B, already inverted for sub, to csea_level.y
//   slice_c_in   chained carry, to csea_level.previous_c_out
//   slice_z      slice sum, from csea_level.z
//   slice_c_out  slice carry, from csea_level.next_c_out
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts result
//   z            W-bit result
//   c_out        final carry-out (for sub: 1 = no borrow)
//   ovf          signed overflow
//   zero         z == 0
// ---------------------------------------------------------------------------
module csea_serial_add_ctrl #(
   parameter int W     = 64,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic             sub,
   input  logic             c_in,
   output logic [SLICE-1:0] slice_x,
   output logic [SLICE-1:0] slice_y,
   output logic             slice_c_in,
   input  logic [SLICE-1:0] slice_z,
   input  logic             slice_c_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     z,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = W / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (((W % SLICE) != 0) || (SLICE != 8)) begin : g_param_check
      $fatal(1, "csea_serial_add_ctrl: W must be a multiple of SLICE and SLICE must be 8");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [IW-1:0]  idx;
   logic           carry;
   logic [W-1:0]   xa;
   logic [W-1:0]   yb;
   logic [W-1:0]   acc;
   logic [W-1:0]   acc_next;
   logic           last;
   int             base;

   // Next-state and output decode. The partial sum is collected in acc and
   // copied to z only when the operation completes. This keeps the previous
   // result stable on z for the whole time the next operation is running.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      slice_x    = '0;
      slice_y    = '0;
      slice_c_in = 1'b0;
      acc_next   = acc;
      base       = int'(idx) * SLICE;
      last       = (idx == IW'(N - 1));
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            slice_x                   = xa[base +: SLICE];
            slice_y                   = yb[base +: SLICE];
            slice_c_in                = carry;
            acc_next[base +: SLICE]   = slice_z;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers. Subtraction is performed as A + ~B + 1:
   // B is inverted when it is captured, and the carry is preloaded with 1.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         xa    <= '0;
         yb    <= '0;
         acc   <= '0;
         z     <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xa    <= x;
                  yb    <= sub ? ~y : y;
                  carry <= sub ? 1'b1 : c_in;
                  idx   <= '0;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= slice_c_out;
               idx   <= idx + 1'b1;
               if (last) begin
                  z     <= acc_next;
                  c_out <= slice_c_out;
                  zero  <= (acc_next == '0);
                  ovf   <= (xa[W-1] == yb[W-1]) & (acc_next[W-1] != xa[W-1]);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
